// File: rtl/ram_4x4_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_4x4_ctrl_if
// Description : Bundle of the request, response and RAM-port signals that
//               connect ram_4x4_ctrl to its requester and to the 4-bit
//               synchronous RAM.
//                 slave  - the controller side (takes requests, drives RAM)
//                 master - the environment side (requester + RAM)
//               Signals:
//                 REQ_VALID/REQ_READY/REQ_WR/REQ_ADDR/REQ_DATA : request
//                 RSP_VALID/RSP_READY/RSP_DATA/RSP_ERR         : response
//                 INIT_DONE                                    : status
//                 RAM_A/RAM_D/RAM_EN/RAM_WR/RAM_Q              : RAM port
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_4x4_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WR;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_DATA;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_ERR;
  logic          INIT_DONE;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic          RAM_EN;
  logic          RAM_WR;
  logic [DW-1:0] RAM_Q;

  modport slave (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, RSP_READY, RAM_Q,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, INIT_DONE,
           RAM_A, RAM_D, RAM_EN, RAM_WR
  );

  modport master (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, RSP_READY, RAM_Q,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, INIT_DONE,
           RAM_A, RAM_D, RAM_EN, RAM_WR
  );
endinterface
`default_nettype wire

// File: rtl/ram_4x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_4x4_ctrl
// Description : Request/response front-end for a 4-bit synchronous RAM.
//               Turns valid/ready read/write requests into single-cycle RAM
//               strobes, tracks the RAM's one-cycle read latency and returns
//               read data on a backpressured response channel. Addresses
//               >= DEPTH are rejected (writes dropped, reads answered with
//               RSP_ERR=1).
// Ports       : CLK  - clock, rising edge
//               RST  - asynchronous reset, active-high
//               bus  - ram_4x4_ctrl_if.slave (request, response, status and
//                      RAM port signals)
// Options     : `define RAM_CTRL_INIT_CLR_EN to write INIT_VAL into every
//               implemented word after reset before accepting requests.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_4x4_ctrl #(
  parameter int            AW       = 4,
  parameter int            DW       = 4,
  parameter int            DEPTH    = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  ram_4x4_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RSP     = 2'd3
  } state_t;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_err;
  logic          r_init_done;

  logic          w_in_range;
  logic          w_req_ready;
  logic          w_accept;
  logic          w_clr_en;
  logic [AW-1:0] w_clr_addr;

  assign w_in_range  = ({1'b0, bus.REQ_ADDR} < c_DEPTH);
  assign w_req_ready = (r_state == S_IDLE) && r_init_done;
  assign w_accept    = bus.REQ_VALID && w_req_ready;

`ifdef RAM_CTRL_INIT_CLR_EN
  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  // r_clr_run is held off for the first edge after reset release so the
  // clear writes occupy cycles 1..DEPTH after release.
  logic          r_clr_run;
  logic [AW-1:0] r_clr_addr;

  assign w_clr_en   = (r_state == S_INIT) && r_clr_run;
  assign w_clr_addr = r_clr_addr;
`else
  assign w_clr_en   = 1'b0;
  assign w_clr_addr = '0;
`endif

  // RAM strobes are combinational so an accepted request hits the RAM in the
  // same cycle; RST forces them low without waiting for an edge.
  assign bus.RAM_EN = !RST && (w_clr_en || (w_accept && w_in_range));
  assign bus.RAM_WR = !RST && (w_clr_en || bus.REQ_WR);
  assign bus.RAM_A  = (r_state == S_INIT) ? w_clr_addr : bus.REQ_ADDR;
  assign bus.RAM_D  = (r_state == S_INIT) ? INIT_VAL   : bus.REQ_DATA;

  assign bus.REQ_READY = w_req_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_ERR   = r_rsp_err;
  assign bus.INIT_DONE = r_init_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_INIT;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_init_done <= 1'b0;
`ifdef RAM_CTRL_INIT_CLR_EN
      r_clr_run   <= 1'b0;
      r_clr_addr  <= '0;
`endif
    end else begin
      case (r_state)
        S_INIT: begin
`ifdef RAM_CTRL_INIT_CLR_EN
          if (!r_clr_run) begin
            r_clr_run <= 1'b1;
          end else if (r_clr_addr == c_LAST) begin
            r_clr_run   <= 1'b0;
            r_init_done <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
`else
          r_init_done <= 1'b1;
          r_state     <= S_IDLE;
`endif
        end

        S_IDLE: begin
          // Writes complete in the accept cycle; only reads leave IDLE.
          if (w_accept && !bus.REQ_WR) begin
            if (w_in_range) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RSP;
            end
          end
        end

        S_RD_WAIT: begin
          // RAM_Q is valid now, one cycle after the read strobe.
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= bus.RAM_Q;
          r_rsp_err   <= 1'b0;
          r_state     <= S_RSP;
        end

        S_RSP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_4x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_4x4_ctrl
// Description : Directed self-checking bench for ram_4x4_ctrl (DEPTH=8,
//               INIT_VAL=0) with a behavioural 16x4 synchronous RAM whose
//               read data passes through a programmable bit mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_4x4_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] mem [16];
  logic [3:0] q_mask;

  ram_4x4_ctrl_if #(.AW(4), .DW(4)) bus ();

  ram_4x4_ctrl #(
    .AW       (4),
    .DW       (4),
    .DEPTH    (8),
    .INIT_VAL (4'h0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM: registered Q, optional masking of read data.
  always @(posedge CLK) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WR) mem[bus.RAM_A] <= bus.RAM_D;
      else            bus.RAM_Q      <= mem[bus.RAM_A] & q_mask;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [3:0] a, input logic [3:0] d);
    bus.REQ_VALID = v;
    bus.REQ_WR    = wr;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = d;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST           = 1'b1;
    q_mask        = 4'hF;
    bus.RSP_READY = 1'b0;
    drive(1'b1, 1'b1, 4'h2, 4'h1);
    step();

    // ---- reset state (request pending must not reach the RAM) ----
    chk("rst_req_ready", {7'd0, bus.REQ_READY}, 8'h0);
    chk("rst_rsp_valid", {7'd0, bus.RSP_VALID}, 8'h0);
    chk("rst_rsp_data",  {4'd0, bus.RSP_DATA},  8'h0);
    chk("rst_rsp_err",   {7'd0, bus.RSP_ERR},   8'h0);
    chk("rst_init_done", {7'd0, bus.INIT_DONE}, 8'h0);
    chk("rst_ram_en",    {7'd0, bus.RAM_EN},    8'h0);
    chk("rst_ram_wr",    {7'd0, bus.RAM_WR},    8'h0);
    drive(1'b0, 1'b0, 4'h0, 4'h0);

`ifdef RAM_CTRL_INIT_CLR_EN
    // ---- clear interrupted at step 4 restarts from address 0 ----
    RST = 1'b0;
    #1;
    step();
    chk("clr0_addr", {4'd0, bus.RAM_A}, 8'h0);
    for (int k = 1; k <= 4; k++) step();
    chk("clr4_addr", {4'd0, bus.RAM_A}, 8'h4);
    RST = 1'b1;
    #1;
    chk("clr_rst_en",   {7'd0, bus.RAM_EN}, 8'h0);
    chk("clr_rst_addr", {4'd0, bus.RAM_A},  8'h0);
    RST = 1'b0;
    #1;
    chk("clr_c0_en", {7'd0, bus.RAM_EN}, 8'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("clr_en",   {7'd0, bus.RAM_EN},    8'h1);
      chk("clr_wr",   {7'd0, bus.RAM_WR},    8'h1);
      chk("clr_addr", {4'd0, bus.RAM_A},     k[7:0]);
      chk("clr_data", {4'd0, bus.RAM_D},     8'h0);
      chk("clr_done", {7'd0, bus.INIT_DONE}, 8'h0);
    end
    step();
    chk("clr_fin_done",  {7'd0, bus.INIT_DONE}, 8'h1);
    chk("clr_fin_ready", {7'd0, bus.REQ_READY}, 8'h1);
    chk("clr_fin_en",    {7'd0, bus.RAM_EN},    8'h0);

    // ---- read of a cleared word ----
    bus.RSP_READY = 1'b1;
    drive(1'b1, 1'b0, 4'h6, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    step();
    chk("clr_rd6_valid", {7'd0, bus.RSP_VALID}, 8'h1);
    chk("clr_rd6_data",  {4'd0, bus.RSP_DATA},  8'h0);
    step();
`else
    // ---- release: operational one edge later ----
    RST = 1'b0;
    #1;
    chk("rel_init_done0", {7'd0, bus.INIT_DONE}, 8'h0);
    chk("rel_ready0",     {7'd0, bus.REQ_READY}, 8'h0);
    step();
    chk("rel_init_done1", {7'd0, bus.INIT_DONE}, 8'h1);
    chk("rel_ready1",     {7'd0, bus.REQ_READY}, 8'h1);
    chk("rel_rsp_valid",  {7'd0, bus.RSP_VALID}, 8'h0);
    chk("rel_ram_en",     {7'd0, bus.RAM_EN},    8'h0);
`endif

    // ---- write 2 <= 1, read 2 ----
    bus.RSP_READY = 1'b1;
    drive(1'b1, 1'b1, 4'h2, 4'h1);
    chk("wr2_en",   {7'd0, bus.RAM_EN}, 8'h1);
    chk("wr2_wr",   {7'd0, bus.RAM_WR}, 8'h1);
    chk("wr2_addr", {4'd0, bus.RAM_A},  8'h2);
    chk("wr2_data", {4'd0, bus.RAM_D},  8'h1);
    step();
    drive(1'b1, 1'b0, 4'h2, 4'h0);
    chk("rd2_en", {7'd0, bus.RAM_EN}, 8'h1);
    chk("rd2_wr", {7'd0, bus.RAM_WR}, 8'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    chk("rd2_c1_valid", {7'd0, bus.RSP_VALID}, 8'h0);
    chk("rd2_c1_ready", {7'd0, bus.REQ_READY}, 8'h0);
    chk("rd2_c1_en",    {7'd0, bus.RAM_EN},    8'h0);
    step();
    chk("rd2_valid", {7'd0, bus.RSP_VALID}, 8'h1);
    chk("rd2_data",  {4'd0, bus.RSP_DATA},  8'h1);
    chk("rd2_err",   {7'd0, bus.RSP_ERR},   8'h0);
    step();
    chk("rd2_hs_valid", {7'd0, bus.RSP_VALID}, 8'h0);
    chk("rd2_hs_ready", {7'd0, bus.REQ_READY}, 8'h1);

    // ---- masking RAM: controller passes data through unchanged ----
    drive(1'b1, 1'b1, 4'h5, 4'hF);
    step();
    q_mask = 4'h3;
    drive(1'b1, 1'b0, 4'h5, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    step();
    chk("mask_valid", {7'd0, bus.RSP_VALID}, 8'h1);
    chk("mask_data",  {4'd0, bus.RSP_DATA},  8'h3);
    step();
    q_mask = 4'hF;

    // ---- out-of-range read 9 and write 12 ----
    drive(1'b1, 1'b0, 4'h9, 4'h0);
    chk("oor_rd_en",    {7'd0, bus.RAM_EN},    8'h0);
    chk("oor_rd_ready", {7'd0, bus.REQ_READY}, 8'h1);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    chk("oor_rd_valid", {7'd0, bus.RSP_VALID}, 8'h1);
    chk("oor_rd_data",  {4'd0, bus.RSP_DATA},  8'h0);
    chk("oor_rd_err",   {7'd0, bus.RSP_ERR},   8'h1);
    step();
    chk("oor_rd_hs", {7'd0, bus.RSP_VALID}, 8'h0);
    drive(1'b1, 1'b1, 4'hC, 4'h7);
    chk("oor_wr_en", {7'd0, bus.RAM_EN}, 8'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    chk("oor_wr_valid", {7'd0, bus.RSP_VALID}, 8'h0);
    chk("oor_wr_ready", {7'd0, bus.REQ_READY}, 8'h1);

    // ---- back-to-back writes at the address boundary, read 7 ----
    drive(1'b1, 1'b1, 4'h7, 4'h6);
    chk("b2b_w7_en", {7'd0, bus.RAM_EN}, 8'h1);
    step();
    drive(1'b1, 1'b1, 4'h3, 4'hA);
    chk("b2b_w3_en",    {7'd0, bus.RAM_EN},    8'h1);
    chk("b2b_w3_ready", {7'd0, bus.REQ_READY}, 8'h1);
    step();
    drive(1'b1, 1'b0, 4'h8, 4'h0);
    chk("rd8_en", {7'd0, bus.RAM_EN}, 8'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    chk("rd8_err", {7'd0, bus.RSP_ERR}, 8'h1);
    step();
    drive(1'b1, 1'b0, 4'h7, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    step();
    chk("rd7_data", {4'd0, bus.RSP_DATA}, 8'h6);
    chk("rd7_err",  {7'd0, bus.RSP_ERR},  8'h0);
    step();

    // ---- backpressure: read 3 held for 5 cycles ----
    bus.RSP_READY = 1'b0;
    drive(1'b1, 1'b0, 4'h3, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {7'd0, bus.RSP_VALID}, 8'h1);
      chk("bp_data",  {4'd0, bus.RSP_DATA},  8'hA);
      chk("bp_ready", {7'd0, bus.REQ_READY}, 8'h0);
      step();
    end
    bus.RSP_READY = 1'b1;
    #1;
    chk("bp_hs_ready0", {7'd0, bus.REQ_READY}, 8'h0);
    step();
    chk("bp_hs_ready1", {7'd0, bus.REQ_READY}, 8'h1);
    chk("bp_hs_valid",  {7'd0, bus.RSP_VALID}, 8'h0);

    // ---- reset while a response is pending ----
    bus.RSP_READY = 1'b0;
    drive(1'b1, 1'b0, 4'h2, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    step();
    chk("mid_pre_valid", {7'd0, bus.RSP_VALID}, 8'h1);
    RST = 1'b1;
    #1;
    chk("mid_rsp_valid", {7'd0, bus.RSP_VALID}, 8'h0);
    chk("mid_rsp_data",  {4'd0, bus.RSP_DATA},  8'h0);
    chk("mid_init_done", {7'd0, bus.INIT_DONE}, 8'h0);
    chk("mid_req_ready", {7'd0, bus.REQ_READY}, 8'h0);
    step();
    RST = 1'b0;
    for (int k = 0; k < 20 && !bus.INIT_DONE; k++) step();
    chk("mid_reinit",     {7'd0, bus.INIT_DONE}, 8'h1);
    chk("mid_post_valid", {7'd0, bus.RSP_VALID}, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_4x4_ctrl.md
Name: ram_4x4_ctrl

Overview:
Request/response front-end that sits directly upstream of the 4-bit synchronous RAM and drives its CLK-domain port (A, D, EN, WR), capturing its registered Q.
- Converts a valid/ready request stream (read or write) into single-cycle RAM strobes.
- Tracks the RAM's one-cycle read latency and returns read data on a valid/ready response channel with backpressure.
- Rejects out-of-range addresses and can optionally clear the RAM after reset.

Parameters:
AW, 4, address width of request and RAM port
DW, 4, data width of request, RAM and response
DEPTH, 8, number of implemented RAM words; addresses >= DEPTH are out of range
INIT_VAL, 0, word written to every address by the post-reset clear (optional feature)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  asynchronous reset, active-high
REQ_VALID  input  1  request present
REQ_READY  output  1  controller can accept a request this cycle
REQ_WR  input  1  1 = write, 0 = read
REQ_ADDR  input  AW  request address
REQ_DATA  input  DW  write data
RSP_VALID  output  1  read response present
RSP_READY  input  1  consumer accepts response
RSP_DATA  output  DW  read data
RSP_ERR  output  1  response belongs to an out-of-range read
INIT_DONE  output  1  controller operational
RAM_A  output  AW  to RAM A
RAM_D  output  DW  to RAM D
RAM_EN  output  1  to RAM EN
RAM_WR  output  1  to RAM WR
RAM_Q  input  DW  from RAM Q

Behaviour:
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, INIT_DONE=0, state=INIT. RAM_EN/RAM_WR are 0 whenever RST=1.
- States: INIT, IDLE, RD_WAIT, RSP.
- Accept condition: REQ_VALID && REQ_READY. REQ_READY is 1 only in IDLE with INIT_DONE=1.
- RAM strobes in IDLE are combinational from the accepted request:
  - RAM_EN = accept && in-range (REQ_ADDR < DEPTH).
  - RAM_WR = REQ_WR, RAM_A = REQ_ADDR, RAM_D = REQ_DATA.
  - Outside accept, RAM_EN=0, except during INIT clear.
- In-range write: one cycle, no response, state stays IDLE. Back-to-back writes run at one per cycle.
- Out-of-range write: accepted and silently dropped (RAM_EN=0). No response.
- In-range read, accepted in cycle 0:
  - RAM samples at the end of cycle 0; state goes to RD_WAIT in cycle 1.
  - At the end of cycle 1, RSP_DATA<=RAM_Q and RSP_ERR<=0.
  - RSP_VALID=1 from cycle 2 (state RSP).
  - Latency: two cycles from accept to RSP_VALID.
- Out-of-range read: RAM_EN=0; next cycle goes to RSP with RSP_DATA=0, RSP_ERR=1. Latency is one cycle.
- RSP state:
  - RSP_VALID, RSP_DATA and RSP_ERR hold stable until RSP_READY=1.
  - On handshake, go to IDLE; RSP_VALID=0 in the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake. At most one read is outstanding.
- REQ_READY=0 in RD_WAIT and RSP, so a write can never race a pending read.
- The controller does not mask data. Any masking applied by the RAM shows up unchanged in RSP_DATA.
- INIT with the macro absent: leave INIT on the first edge after RST deasserts; INIT_DONE=1 and state IDLE from then on.
- Reset mid-operation: any pending read or response is discarded and every output returns to its reset value immediately.
- RSP_READY while RSP_VALID=0 is ignored.

Optional Feature:
RAM_CTRL_INIT_CLR_EN:
- Defined:
  - INIT writes INIT_VAL to addresses 0..DEPTH-1, one per cycle (RAM_EN=1, RAM_WR=1, RAM_A=counter), starting the first cycle after RST deasserts.
  - After the write to DEPTH-1, INIT_DONE=1 and state=IDLE. REQ_READY is first 1 DEPTH+1 cycles after reset release.
  - Reset during the clear restarts it from address 0.
- Undefined: no clear is performed; INIT_DONE=1 one cycle after reset release and RAM contents are unknown.

Test Plan:
- Reset release (macro undefined): INIT_DONE=1 and REQ_READY=1 on the cycle after release; RSP_VALID=0 and RAM_EN=0 throughout.
- Write addr 2 data 0x1, then read addr 2 with RSP_READY=1: RAM_EN pulses once per request; RSP_VALID rises exactly 2 cycles after read accept with RSP_DATA=0x1, RSP_ERR=0.
- Write 0xF to addr 5, read addr 5 against a RAM that masks data to 2 bits: RSP_DATA=0x3, unmodified by the controller.
- Read addr 9 (DEPTH=8): RAM_EN stays 0; RSP_VALID one cycle after accept with RSP_DATA=0, RSP_ERR=1. A write to addr 12 produces no RAM_EN and no response.
- Read addr 3 with RSP_READY held 0 for 5 cycles: RSP_VALID/RSP_DATA stable and REQ_READY=0 for all 5 cycles; REQ_READY=1 one cycle after RSP_READY=1.
- Macro defined: after reset release, 8 consecutive writes of INIT_VAL to addresses 0..7, INIT_DONE=1 at cycle 9; a subsequent read of addr 6 returns 0x0. Asserting RST at clear step 4 restarts the clear at address 0.
